dmem_store_buffer: RTL and testbench
====================================

// Module: dmem_store_buffer
// PURPOSE
// - Data-memory responder at the far end of the core's MEM-stage interface (rd/wr/addr/wdata/funct3 -> rdata).
// - Stores enter a SB_DEPTH-entry FIFO store buffer and drain into a single-port word RAM in idle cycles.
// - Loads are answered combinationally in the request cycle, merged with pending buffered stores.
// - Asserts core_stall when a store finds the buffer full (or on an unforwardable load hit, see CONFIGURATION).
// PARAMETERS
// - ADDR_W    9   byte address width; RAM holds 2**(ADDR_W-2) 32-bit words
// - DATA_W    32  data width; only 32 is supported
// - SB_DEPTH  4   store-buffer entries, >=2, power of two
// PORTS
// - clk          in   1                      clock
// - reset        in   1                      synchronous, active-high
// - core_rd      in   1                      load request (MemRead)
// - core_wr      in   1                      store request (MemWrite)
// - core_addr    in   ADDR_W                 byte address
// - core_wdata   in   DATA_W                 store data, right-aligned
// - core_funct3  in   3                      size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
// - core_rdata   out  DATA_W                 load data, extended per funct3
// - core_stall   out  1                      request not accepted this cycle; core holds the request
// - access_err   out  1                      registered 1-cycle pulse: misaligned/illegal access dropped
// - sb_count     out  $clog2(SB_DEPTH+1)     occupied buffer entries
// - sb_empty     out  1                      sb_count==0
// BEHAVIOUR
// - Reset: buffer cleared, pending stores discarded (never written); sb_count=0, sb_empty=1, access_err=0.
// - RAM contents are not reset.
// - Entry = {word_addr, 32b data lane-aligned, 4b byte-enable}. SB: BE=1<<a[1:0]; SH: BE=3<<a[1:0]; SW: BE=4'hF.
// - Byte order is little-endian: byte k lives in bits [8k+7:8k].
// - Legality:
//   - H needs a[0]=0; W needs a[1:0]=0.
//   - funct3 011/110/111 is illegal; store with funct3 100/101 is illegal.
//   - core_rd&core_wr together is illegal.
//   - Illegal access: no state change, core_rdata=0, no stall, access_err=1 on the next cycle.
// - Store accept: push at posedge when core_wr & legal & !core_stall.
// - Store stall: buffer full -> core_stall=1 for exactly 1 cycle; that cycle's drain frees a slot.
// - Drain: pop the oldest entry into the RAM (byte-enable write) at posedge when non-empty
//   and ((core_rd==0 && core_wr==0) || core_stall==1).
// - No push+pop in the same cycle, except a pop during a stall cycle.
// - Load, legal, not stalled:
//   - word = RAM[word_addr], overlaid oldest->youngest by every matching buffer entry's enabled bytes.
//   - Then select byte/half by a[1:0]; sign-extend for B/H, zero-extend for BU/HU.
// - core_rdata=0 whenever core_rd=0 or core_stall=1.
// - A load never pushes or pops, so it blocks the drain that cycle.
// - Load latency is 0 cycles; store visibility is 0 cycles (forwarded) or after drain (RAM).
// - Pointer wrap modulo SB_DEPTH; sb_count never exceeds SB_DEPTH.
// - Reset mid-stall: stall drops the next cycle and the held store is lost.
// CONFIGURATION
// - DMEM_SB_FWD_EN defined: store-to-load merge as above; loads never stall.
// - DMEM_SB_FWD_EN undefined: a load whose word_addr matches any entry asserts core_stall.
//   - Draining continues each stalled cycle until no entry matches.
//   - The load is then served from RAM (stall cycles = index of youngest matching entry + 1).
// TESTING
// - SW 0x11223344 @0x100, next cycle LW @0x100 -> rdata 0x11223344.
//   - FWD_EN: no stall. No FWD_EN: 1 stall cycle.
// - SW 0x11223344 @0x100, SB 0xAA @0x101, 2 idle cycles:
//   - LW @0x100 -> 0x1122AA44.
//   - LB @0x101 -> 0xFFFFFFAA.
//   - LBU @0x101 -> 0x000000AA.
//   - LHU @0x102 -> 0x00001122.
// - 5 back-to-back SW to 0x000..0x010 (SB_DEPTH=4):
//   - sb_count 1,2,3,4; 5th store sees core_stall=1 for one cycle, then accepted.
//   - After idles: all 5 words read back.
// - LW @0x102 -> access_err pulse next cycle, rdata 0, sb_count unchanged.
//   - SH @0x0FF -> same, no RAM write.
// - Fill 3 entries, assert reset 1 cycle -> sb_count=0, sb_empty=1.
//   - LW of those addresses returns prior RAM contents.
// - Two SB to 0x200 (0x01 then 0x02) pending, LBU @0x200 -> 0x02 (youngest wins).

Source files
------------

// File: rtl/dmem_store_buffer.sv
// Data memory with a FIFO store buffer that drains into a single-port word RAM in idle cycles.
// Build option: define DMEM_SB_FWD_EN to forward buffered stores into loads instead of stalling them.
module dmem_store_buffer #(
  parameter int ADDR_W   = 9,
  parameter int DATA_W   = 32,
  parameter int SB_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          core_rd,
  input  logic                          core_wr,
  input  logic [ADDR_W-1:0]             core_addr,
  input  logic [DATA_W-1:0]             core_wdata,
  input  logic [2:0]                    core_funct3,
  output logic [DATA_W-1:0]             core_rdata,
  output logic                          core_stall,
  output logic                          access_err,
  output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
  output logic                          sb_empty
);

  localparam int WA_W  = ADDR_W - 2;
  localparam int WORDS = 2 ** WA_W;
  localparam int PTR_W = $clog2(SB_DEPTH);
  localparam int CNT_W = $clog2(SB_DEPTH + 1);

  logic [WA_W-1:0]  sb_wa_r   [SB_DEPTH];
  logic [31:0]      sb_data_r [SB_DEPTH];
  logic [3:0]       sb_be_r   [SB_DEPTH];
  logic [31:0]      mem       [WORDS];

  logic [PTR_W-1:0] rd_ptr_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] slot_s;
  logic [CNT_W-1:0] count_r;
  logic             access_err_r;

  logic [WA_W-1:0]  req_wa_s;
  logic             access_s;
  logic             fmt_ok_s;
  logic             align_ok_s;
  logic             legal_s;
  logic             illegal_s;
  logic             full_s;
  logic             hit_s;
  logic             store_stall_s;
  logic             load_stall_s;
  logic             push_s;
  logic             pop_s;
  logic [31:0]      word_s;

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] ofs);
    case (size)
      2'b00:   byte_en = 4'b0001 << ofs;
      2'b01:   byte_en = 4'b0011 << ofs;
      default: byte_en = 4'b1111;
    endcase
  endfunction

  // Replicate the right-aligned store data across the word so any lane picks it up.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      2'b00:   lane_data = {4{d[7:0]}};
      2'b01:   lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] base, input logic [31:0] upd,
                                              input logic [3:0] be);
    logic [31:0] r;
    r = base;
    for (int k = 0; k < 4; k++) begin
      if (be[k]) begin
        r[8*k +: 8] = upd[8*k +: 8];
      end else begin
        r[8*k +: 8] = base[8*k +: 8];
      end
    end
    merge_bytes = r;
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] ofs,
                                              input logic [31:0] word);
    logic [31:0] sh;
    sh = word >> {ofs, 3'b000};
    case (f3)
      3'b000:  load_extend = {{24{sh[7]}}, sh[7:0]};
      3'b001:  load_extend = {{16{sh[15]}}, sh[15:0]};
      3'b100:  load_extend = {24'h000000, sh[7:0]};
      3'b101:  load_extend = {16'h0000, sh[15:0]};
      default: load_extend = sh;
    endcase
  endfunction

  // Request decode: size/sign legality, alignment and the rd+wr conflict.
  always_comb begin
    req_wa_s   = core_addr[ADDR_W-1:2];
    access_s   = core_rd | core_wr;
    fmt_ok_s   = 1'b1;
    align_ok_s = 1'b1;
    case (core_funct3)
      3'b000: begin
        fmt_ok_s   = 1'b1;
        align_ok_s = 1'b1;
      end
      3'b001: align_ok_s = ~core_addr[0];
      3'b010: align_ok_s = (core_addr[1:0] == 2'b00);
      3'b100: fmt_ok_s = ~core_wr;
      3'b101: begin
        fmt_ok_s   = ~core_wr;
        align_ok_s = ~core_addr[0];
      end
      default: fmt_ok_s = 1'b0;
    endcase
    legal_s   = fmt_ok_s & align_ok_s & ~(core_rd & core_wr);
    illegal_s = access_s & ~legal_s;
  end

  // Walk the live entries oldest to youngest: detect word hits and build the forwarded word.
  always_comb begin
    word_s = mem[req_wa_s];
    hit_s  = 1'b0;
    slot_s = rd_ptr_r;
    for (int i = 0; i < SB_DEPTH; i++) begin
      slot_s = rd_ptr_r + PTR_W'(i);
      if ((CNT_W'(i) < count_r) && (sb_wa_r[slot_s] == req_wa_s)) begin
        hit_s = 1'b1;
`ifdef DMEM_SB_FWD_EN
        word_s = merge_bytes(word_s, sb_data_r[slot_s], sb_be_r[slot_s]);
`endif
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Stall, push/pop handshake and load data.
  always_comb begin
    full_s        = (count_r == CNT_W'(SB_DEPTH));
    store_stall_s = core_wr & legal_s & full_s;
`ifdef DMEM_SB_FWD_EN
    load_stall_s  = 1'b0;
`else
    // Without forwarding a load waits until every matching entry has drained.
    load_stall_s  = core_rd & legal_s & hit_s;
`endif
    core_stall = store_stall_s | load_stall_s;
    push_s     = ~reset & core_wr & legal_s & ~core_stall;
    pop_s      = ~reset & (count_r != {CNT_W{1'b0}}) & (~access_s | core_stall);
    if (core_rd & legal_s & ~core_stall) begin
      core_rdata = load_extend(core_funct3, core_addr[1:0], word_s);
    end else begin
      core_rdata = {DATA_W{1'b0}};
    end
  end

  // Pointers, occupancy and the registered error pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_r     <= {PTR_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      access_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r      <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
      access_err_r <= illegal_s;
    end
  end

  // Capture accepted stores into the tail slot.
  always_ff @(posedge clk) begin
    if (push_s) begin
      sb_wa_r[wr_ptr_r]   <= req_wa_s;
      sb_data_r[wr_ptr_r] <= lane_data(core_funct3[1:0], core_wdata);
      sb_be_r[wr_ptr_r]   <= byte_en(core_funct3[1:0], core_addr[1:0]);
    end
  end

  // Byte-enable write of the oldest entry into the RAM.
  always_ff @(posedge clk) begin
    if (pop_s) begin
      for (int k = 0; k < 4; k++) begin
        if (sb_be_r[rd_ptr_r][k]) begin
          mem[sb_wa_r[rd_ptr_r]][8*k +: 8] <= sb_data_r[rd_ptr_r][8*k +: 8];
        end
      end
    end
  end

  assign sb_count   = count_r;
  assign sb_empty   = (count_r == {CNT_W{1'b0}});
  assign access_err = access_err_r;

endmodule

// File: tb/tb_dmem_store_buffer.sv
// Self-checking bench for dmem_store_buffer: directed vector table, hand-written corner
// sequences and randomized traffic checked against a byte-level queue model.
module tb_dmem_store_buffer;
  localparam int ADDR_W   = 9;
  localparam int SB_DEPTH = 4;
  localparam int CNT_W    = $clog2(SB_DEPTH + 1);
`ifdef DMEM_SB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic              core_rd;
  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;
  logic [31:0]       core_wdata;
  logic [2:0]        core_funct3;
  logic [31:0]       core_rdata;
  logic              core_stall;
  logic              access_err;
  logic [CNT_W-1:0]  sb_count;
  logic              sb_empty;

  always #5 clk = ~clk;

  dmem_store_buffer #(.ADDR_W(ADDR_W), .DATA_W(32), .SB_DEPTH(SB_DEPTH)) dut (
    .clk(clk), .reset(reset), .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr),
    .core_wdata(core_wdata), .core_funct3(core_funct3), .core_rdata(core_rdata),
    .core_stall(core_stall), .access_err(access_err), .sb_count(sb_count), .sb_empty(sb_empty)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: pending stores as (byte address, size, value) over a flat byte RAM.
  typedef struct { int addr; int nbytes; logic [31:0] value; } st_t;
  st_t        sbq[$];
  logic [7:0] ram_m [512];
  logic       err_m;
  logic [31:0] last_rdata;
  logic        last_stall;

  typedef struct {
    bit rd; bit wr; int addr; logic [31:0] wdata; int f3;
    logic [31:0] rdata; bit stall; int cnt; bit err;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [7:0] w);
    return {8'hC0, w, ~w, 8'h5A};
  endfunction

  function automatic bit legal_m(input bit rd, input bit wr, input int addr, input int f3);
    if (!rd && !wr) return 1'b1;
    if (rd && wr) return 1'b0;
    if (f3 == 3 || f3 >= 6) return 1'b0;
    if (wr && f3 >= 4) return 1'b0;
    if ((f3 % 4) == 1 && (addr % 2) != 0) return 1'b0;
    if (f3 == 2 && (addr % 4) != 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int nbytes_m(input int f3);
    return (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
  endfunction

  function automatic bit has_match(input int addr);
    foreach (sbq[i]) if (sbq[i].addr / 4 == addr / 4) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] load_m(input int addr, input int f3);
    logic [7:0]  b [4];
    logic [31:0] w;
    int          a;
    for (int k = 0; k < 4; k++) b[k] = ram_m[(addr / 4) * 4 + k];
    foreach (sbq[i]) begin
      for (int j = 0; j < sbq[i].nbytes; j++) begin
        a = sbq[i].addr + j;
        if (a / 4 == addr / 4) b[a % 4] = sbq[i].value[8*j +: 8];
      end
    end
    w = {b[3], b[2], b[1], b[0]} >> (8 * (addr % 4));
    case (f3)
      0:       return {{24{w[7]}}, w[7:0]};
      1:       return {{16{w[15]}}, w[15:0]};
      4:       return {24'h000000, w[7:0]};
      5:       return {16'h0000, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic drain_m();
    st_t e;
    e = sbq.pop_front();
    for (int j = 0; j < e.nbytes; j++) ram_m[e.addr + j] = e.value[8*j +: 8];
  endtask

  // One clock of traffic: drive, compare combinational outputs at the falling edge,
  // advance the model, then compare registered outputs just after the rising edge.
  task automatic step(input bit rst, input bit rd, input bit wr, input int addr,
                      input logic [31:0] wd, input int f3);
    bit          lg;
    bit          st;
    logic [31:0] rdv;
    st_t         e;
    reset = rst; core_rd = rd; core_wr = wr; core_addr = addr[ADDR_W-1:0];
    core_wdata = wd; core_funct3 = f3[2:0];
    lg  = legal_m(rd, wr, addr, f3);
    st  = 1'b0;
    rdv = 32'h0;
    if ((rd || wr) && lg) begin
      if (wr) st = (sbq.size() == SB_DEPTH);
      else if (!FWD) st = has_match(addr);
      if (rd && !st) rdv = load_m(addr, f3);
    end
    @(negedge clk);
    check("stall", {31'b0, core_stall}, {31'b0, st});
    check("rdata", core_rdata, rdv);
    last_stall = core_stall;
    last_rdata = core_rdata;
    if (rst) begin
      sbq.delete();
      err_m = 1'b0;
    end else begin
      err_m = (rd || wr) && !lg;
      if (wr && lg && !st) begin
        e.addr = addr; e.nbytes = nbytes_m(f3); e.value = wd;
        sbq.push_back(e);
      end else if (sbq.size() > 0 && ((!rd && !wr) || st)) begin
        drain_m();
      end
    end
    @(posedge clk);
    #1;
    check("sb_count", 32'(sb_count), sbq.size());
    check("sb_empty", {31'b0, sb_empty}, {31'b0, (sbq.size() == 0)});
    check("access_err", {31'b0, access_err}, {31'b0, err_m});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 0, 32'h0, 0);
  endtask

  task automatic add(input bit rd, input bit wr, input int addr, input logic [31:0] wd,
                     input int f3, input logic [31:0] rdat, input bit st, input int cnt,
                     input bit err);
    vec_t r;
    r.rd = rd; r.wr = wr; r.addr = addr; r.wdata = wd; r.f3 = f3;
    r.rdata = rdat; r.stall = st; r.cnt = cnt; r.err = err;
    tbl.push_back(r);
  endtask

  initial begin
    logic [31:0] top_w;
    reset = 1'b1; core_rd = 1'b0; core_wr = 1'b0; core_addr = '0;
    core_wdata = 32'h0; core_funct3 = 3'b000;
    err_m = 1'b0;

    step(1'b1, 1'b0, 1'b0, 0, 32'h0, 0);
    check("rst_count", 32'(sb_count), 32'd0);
    check("rst_empty", {31'b0, sb_empty}, 32'd1);
    check("rst_err", {31'b0, access_err}, 32'd0);

    // Give every RAM word a known value.
    for (int w = 0; w < 128; w++) begin
      step(1'b0, 1'b0, 1'b1, 4 * w, init_word(8'(w)), 2);
      idle();
    end

    // Directed table: rd, wr, addr, wdata, f3, rdata, stall, count after, err after.
    add(0, 1, 'h100, 32'h11223344, 2, 32'h0, 0, 1, 0);
    add(1, 0, 'h100, 32'h0, 2, FWD ? 32'h11223344 : 32'h0, !FWD, FWD ? 1 : 0, 0);
    add(1, 0, 'h100, 32'h0, 2, 32'h11223344, 0, FWD ? 1 : 0, 0);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    add(0, 1, 'h100, 32'h11223344, 2, 32'h0, 0, 1, 0);
    add(0, 1, 'h101, 32'h000000AA, 0, 32'h0, 0, 2, 0);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, 1, 0);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 'h100, 32'h0, 2, 32'h1122AA44, 0, 0, 0);
    add(1, 0, 'h101, 32'h0, 0, 32'hFFFFFFAA, 0, 0, 0);
    add(1, 0, 'h101, 32'h0, 4, 32'h000000AA, 0, 0, 0);
    add(1, 0, 'h102, 32'h0, 5, 32'h00001122, 0, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 4 * i, 32'hA0000000 + 32'(i), 2, 32'h0, 0, i + 1, 0);
    add(0, 1, 'h010, 32'hA0000004, 2, 32'h0, 1, 3, 0);
    add(0, 1, 'h010, 32'hA0000004, 2, 32'h0, 0, 4, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 32'h0, 0, 32'h0, 0, 3 - i, 0);
    for (int i = 0; i < 5; i++) add(1, 0, 4 * i, 32'h0, 2, 32'hA0000000 + 32'(i), 0, 0, 0);
    add(0, 1, 'h020, 32'h0BADF00D, 2, 32'h0, 0, 1, 0);
    add(1, 0, 'h102, 32'h0, 2, 32'h0, 0, 1, 1);
    add(0, 1, 'h0FF, 32'h0000BEEF, 1, 32'h0, 0, 1, 1);
    add(1, 1, 'h000, 32'h12345678, 2, 32'h0, 0, 1, 1);
    add(1, 0, 'h000, 32'h0, 3, 32'h0, 0, 1, 1);
    add(0, 1, 'h000, 32'h12345678, 4, 32'h0, 0, 1, 1);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    add(1, 0, 'h0FC, 32'h0, 2, init_word(8'd63), 0, 0, 0);
    add(1, 0, 'h020, 32'h0, 2, 32'h0BADF00D, 0, 0, 0);
    // 0x200 lies outside the 9-bit byte space; the top word plays the same role.
    add(0, 1, 'h1FC, 32'h00000001, 0, 32'h0, 0, 1, 0);
    add(0, 1, 'h1FC, 32'h00000002, 0, 32'h0, 0, 2, 0);
    add(1, 0, 'h1FC, 32'h0, 4, FWD ? 32'h2 : 32'h0, !FWD, FWD ? 2 : 1, 0);
    add(1, 0, 'h1FC, 32'h0, 4, FWD ? 32'h2 : 32'h0, !FWD, FWD ? 2 : 0, 0);
    add(1, 0, 'h1FC, 32'h0, 4, 32'h2, 0, FWD ? 2 : 0, 0);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, FWD ? 1 : 0, 0);
    add(0, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0);
    top_w = init_word(8'd127);
    add(1, 0, 'h1FC, 32'h0, 2, {top_w[31:8], 8'h02}, 0, 0, 0);

    foreach (tbl[i]) begin
      step(1'b0, tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].f3);
      check($sformatf("row%0d_rdata", i), last_rdata, tbl[i].rdata);
      check($sformatf("row%0d_stall", i), {31'b0, last_stall}, {31'b0, tbl[i].stall});
      check($sformatf("row%0d_count", i), 32'(sb_count), tbl[i].cnt);
      check($sformatf("row%0d_err", i), {31'b0, access_err}, {31'b0, tbl[i].err});
    end

    // Reset discards pending stores.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 'h040 + 4 * i, 32'h11111111 * (i + 1), 2);
    check("pre_reset_count", 32'(sb_count), 32'd3);
    step(1'b1, 1'b0, 1'b0, 0, 32'h0, 0);
    check("post_reset_count", 32'(sb_count), 32'd0);
    check("post_reset_empty", {31'b0, sb_empty}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 1'b0, 'h040 + 4 * i, 32'h0, 2);
      check("post_reset_ram", last_rdata, init_word(8'(16 + i)));
    end

    // Reset during a full-buffer stall: the held store is lost.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 'h050 + 4 * i, 32'h77000000 + 32'(i), 2);
    step(1'b1, 1'b0, 1'b1, 'h060, 32'h99999999, 2);
    check("midstall_stall", {31'b0, last_stall}, 32'd1);
    check("midstall_count", 32'(sb_count), 32'd0);
    step(1'b0, 1'b1, 1'b0, 'h060, 32'h0, 2);
    check("midstall_drop", {31'b0, last_stall}, 32'd0);
    check("midstall_lost", last_rdata, init_word(8'd24));

    // Randomized traffic over a small window so buffer hits are frequent.
    for (int n = 0; n < 800; n++) begin
      int  op;
      int  a;
      int  sel;
      bit  rst;
      op  = int'($urandom_range(0, 9));
      a   = int'($urandom_range(0, 31));
      sel = int'($urandom_range(0, 4));
      rst = ($urandom_range(0, 149) == 0);
      if (op <= 2) step(rst, 1'b0, 1'b1, a, $urandom, int'($urandom_range(0, 2)));
      else if (op <= 5) step(rst, 1'b1, 1'b0, a, 32'h0, (sel < 3) ? sel : sel + 1);
      else if (op <= 8) step(rst, 1'b0, 1'b0, a, 32'h0, 0);
      else step(rst, 1'b1, 1'($urandom_range(0, 1)), a, $urandom, int'($urandom_range(0, 7)));
    end
    for (int i = 0; i < SB_DEPTH + 1; i++) idle();
    for (int w = 0; w < 8; w++) step(1'b0, 1'b1, 1'b0, 4 * w, 32'h0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
